branch_history_table: RTL and testbench

BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

---
 rtl/branch_history_table.sv | 85 ++++++++
 tb/tb_branch_history_table.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
// Branch history table of saturating counters: registered one-cycle prediction, same-edge update.
// Optional gshare indexing (PC XOR global history) is enabled by defining BHT_GSHARE_EN.
module branch_history_table #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_valid,
    input  logic [31:0]           lookup_pc,
    output logic                  predict_valid,
    output logic                  predict_taken,
    output logic [INDEX_BITS-1:0] predict_index,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic                  update_taken
);

    // Handshake: there is no backpressure. A lookup or update is accepted on every rising
    // edge where its valid is high; predict_valid pulses exactly one cycle after a lookup.

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

    logic [CTR_BITS-1:0]   counters [ENTRIES];
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                              update_pc[31:INDEX_BITS+2], update_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    // Both indices use the history as it stood before this cycle's shift.
    assign lookup_idx = lookup_pc[INDEX_BITS+1:2] ^ ghr;
    assign update_idx = update_pc[INDEX_BITS+1:2] ^ ghr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr <= '0;
        end else if (update_valid) begin
            ghr <= {ghr[INDEX_BITS-2:0], update_taken};
        end
    end
`else
    assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
    assign update_idx = update_pc[INDEX_BITS+1:2];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= CTR_INIT;
            end
        end else if (update_valid) begin
            if (update_taken) begin
                if (counters[update_idx] != CTR_MAX) begin
                    counters[update_idx] <= counters[update_idx] + CTR_ONE;
                end
            end else if (counters[update_idx] != '0) begin
                counters[update_idx] <= counters[update_idx] - CTR_ONE;
            end
        end
    end

    // Reads the counter array before this edge's update lands: no bypass on same-index hits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            predict_valid <= 1'b0;
            predict_taken <= 1'b0;
            predict_index <= '0;
        end else begin
            predict_valid <= lookup_valid;
            if (lookup_valid) begin
                predict_taken <= counters[lookup_idx][CTR_BITS-1];
                predict_index <= lookup_idx;
            end
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: directed literal cases plus randomized
// traffic compared every cycle against an arithmetic model of the counter table.
module tb_branch_history_table;

    localparam int IB = 6;
    localparam int CB = 2;
    localparam int ENTRIES = 1 << IB;
    localparam int CMAX = (1 << CB) - 1;
    localparam int CINIT = (1 << (CB - 1)) - 1;
    localparam int W = 2 + IB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lookup_valid = 1'b0;
    logic [31:0]   lookup_pc = '0;
    logic          predict_valid;
    logic          predict_taken;
    logic [IB-1:0] predict_index;
    logic          update_valid = 1'b0;
    logic [31:0]   update_pc = '0;
    logic          update_taken = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    branch_history_table #(.INDEX_BITS(IB), .CTR_BITS(CB)) dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .predict_valid(predict_valid),
        .predict_taken(predict_taken),
        .predict_index(predict_index),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_taken (update_taken)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // behavioural model: counters as plain integers, index by division/modulo
    int          m_ctr [ENTRIES];
    int          m_ghr;
    logic        m_valid, m_taken;
    int          m_index;
    logic [W-1:0] exp_q[$];

    function automatic int pc_index(logic [31:0] pc, int hist);
        return ((int'(pc >> 2) % ENTRIES) ^ hist) % ENTRIES;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = CINIT;
        m_ghr = 0;
        m_valid = 1'b0;
        m_taken = 1'b0;
        m_index = 0;
    endtask

    always @(posedge reset) model_clear();

    always @(posedge clk) begin
        int li, ui, hist;
        if (reset) begin
            model_clear();
        end else begin
`ifdef BHT_GSHARE_EN
            hist = m_ghr;
`else
            hist = 0;
`endif
            li = pc_index(lookup_pc, hist);
            ui = pc_index(update_pc, hist);
            m_valid = lookup_valid;
            if (lookup_valid) begin
                m_taken = (m_ctr[li] >= (1 << (CB - 1)));
                m_index = li;
            end
            if (update_valid) begin
                if (update_taken) m_ctr[ui] = (m_ctr[ui] + 1 > CMAX) ? CMAX : m_ctr[ui] + 1;
                else              m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
                m_ghr = ((m_ghr << 1) | int'(update_taken)) % ENTRIES;
            end
        end
        exp_q.push_back({m_valid, m_taken, IB'(m_index)});
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (reset) e = '0;
            chk("sb_valid", 32'(predict_valid), 32'(e[W-1]));
            chk("sb_taken", 32'(predict_taken), 32'(e[W-2]));
            chk("sb_index", 32'(predict_index), 32'(e[IB-1:0]));
        end
    end

    // driver tasks: each step presents inputs for exactly one rising edge
    task automatic step(input logic lv, input logic [31:0] lpc,
                        input logic uv, input logic [31:0] upc, input logic ut);
        @(negedge clk);
        #1;
        lookup_valid = lv;
        lookup_pc    = lpc;
        update_valid = uv;
        update_pc    = upc;
        update_taken = ut;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic t);
        step(1'b0, 32'h0, 1'b1, pc, t);
    endtask

    task automatic lk(input logic [31:0] pc, input logic exp_t, input int exp_i, input string name);
        step(1'b1, pc, 1'b0, 32'h0, 1'b0);
        chk({name, "_valid"}, 32'(predict_valid), 32'd1);
        chk({name, "_taken"}, 32'(predict_taken), 32'(exp_t));
        chk({name, "_index"}, 32'(predict_index), 32'(exp_i));
    endtask

    initial begin
        #2;
        chk("reset_valid", 32'(predict_valid), 32'd0);
        chk("reset_taken", 32'(predict_taken), 32'd0);
        chk("reset_index", 32'(predict_index), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

`ifndef BHT_GSHARE_EN
        lk(32'h100, 1'b0, 0, "first_lookup");
        idle();
        chk("hold_valid", 32'(predict_valid), 32'd0);
        chk("hold_index", 32'(predict_index), 32'd0);
        repeat (3) upd(32'h104, 1'b1);
        lk(32'h104, 1'b1, 1, "sat_hi");
        upd(32'h104, 1'b0);
        lk(32'h104, 1'b1, 1, "weak_taken");
        repeat (3) upd(32'h104, 1'b0);
        lk(32'h104, 1'b0, 1, "sat_lo");
        upd(32'h104, 1'b1);
        lk(32'h104, 1'b0, 1, "from_zero");
        repeat (2) upd(32'h100, 1'b1);
        lk(32'h200, 1'b1, 0, "alias");
        lk(32'h108, 1'b0, 2, "neighbour");
        step(1'b1, 32'h14, 1'b1, 32'h14, 1'b1);
        chk("rbw_taken", 32'(predict_taken), 32'd0);
        chk("rbw_index", 32'(predict_index), 32'd5);
        lk(32'h14, 1'b1, 5, "after_rbw");
        upd(32'h14, 1'b1);
        lk(32'h14, 1'b1, 5, "pre_reset");
        #1;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h14;
        update_valid = 1'b1;
        update_pc    = 32'h14;
        update_taken = 1'b1;
        reset        = 1'b1;
        #1;
        chk("async_valid", 32'(predict_valid), 32'd0);
        chk("async_taken", 32'(predict_taken), 32'd0);
        chk("async_index", 32'(predict_index), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        lk(32'h14, 1'b0, 5, "post_reset");
        lk(32'h100, 1'b0, 0, "post_reset_idx0");
`else
        upd(32'h0, 1'b1);
        upd(32'h4, 1'b1);
        lk(32'h0, 1'b0, 3, "gshare_idx3");
        lk(32'hC, 1'b1, 0, "gshare_idx0");
`endif

        repeat (600) begin
            logic        lv, uv, ut;
            logic [31:0] lpc, upc;
            lv  = 1'($urandom_range(0, 1));
            uv  = ($urandom_range(0, 3) != 0);
            ut  = 1'($urandom_range(0, 1));
            lpc = ($urandom << 8) | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
            upc = ($urandom_range(0, 1) == 1) ? lpc
                  : (($urandom << 8) | 32'($urandom_range(0, 7) << 2));
            step(lv, lpc, uv, upc, ut);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
